// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared FSM encoding and default sizing for the data-memory responder
package dmem_responder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam int DEF_DEPTH       = 64;
   localparam int DEF_WAIT_CYCLES = 2;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 32 word storage, synchronous write, asynchronous read, never cleared
module dmem_array
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                     clk_i,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] addr_i,
   input  logic [31:0]              wdata_i,
   output logic [31:0]              rdata_o
);

   logic [31:0] mem_q [DEPTH];

   // write the addressed word on the access edge; contents survive reset
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: wait-state memory responder that stalls the pipeline's memory stage
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH       = DEF_DEPTH,
   parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        reqM,
   input  logic        weM,
   input  logic [31:0] addrM,
   input  logic [31:0] writedataM,
   output logic [31:0] readdataM,
   output logic        stallM,
   output logic        errM
);

   localparam int         AW = $clog2(DEPTH);
   localparam logic [3:0] WC = 4'(WAIT_CYCLES);

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;
   logic [AW-1:0] idx;
   logic [31:0]   mem_rd;
   logic          mis, acc, mem_we;
   logic          unused_addr;

   // upper address bits wrap around, so only the word index is decoded
   assign idx         = addrM[AW+1:2];
   assign mis         = |addrM[1:0];
   assign unused_addr = ^addrM[31:AW+2];

   // the access edge: straight from IDLE with no wait states, otherwise the last BUSY cycle
   assign acc    = reqM & (((state_q == IDLE) & (WC == 4'd0)) | ((state_q == BUSY) & (cnt_q == 4'd0)));
   assign mem_we = acc & weM & ~mis;
   assign stallM = reqM & (state_q != DONE) & ~reset;

   assign readdataM = rdata_q;
   assign errM      = err_q;

   dmem_array #(.DEPTH(DEPTH)) u_array (
      .clk_i   (clk),
      .we_i    (mem_we),
      .addr_i  (idx),
      .wdata_i (writedataM),
      .rdata_o (mem_rd)
   );

   // next state, wait counter and output register values
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (reqM) begin
               state_d = (WC == 4'd0) ? DONE : BUSY;
               cnt_d   = (WC == 4'd0) ? cnt_q : WC - 4'd1;
            end
         end
         BUSY: begin
            state_d = !reqM ? IDLE : (cnt_q == 4'd0) ? DONE : BUSY;
            cnt_d   = (reqM && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
         end
         default: state_d = IDLE;
      endcase
      rdata_d = (acc & mis) ? 32'd0 : (acc & ~weM) ? mem_rd : rdata_q;
      err_d   = acc & mis;
   end

   // FSM state, counter and registered outputs; reset cancels any access in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

endmodule
